// File: rtl/weight_mem_pkg.sv
// Shared definitions for the double-buffered weight bank memory:
// default geometry, load FSM state encoding and the ld_len width helper.
package weight_mem_pkg;

  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_BANKS  = 4;

  // Load FSM: IDLE waits for ld_start, LOAD streams words into the shadow page.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } ld_state_e;

  // ld_len must express 0 .. NUM_BANKS*2**ADDR_WIDTH inclusive.
  function automatic int ld_len_width(input int addr_width, input int num_banks);
    return addr_width + $clog2(num_banks) + 1;
  endfunction

endpackage

// File: rtl/weight_bank_sram.sv
// One bank of weight storage: simple dual-port RAM, one write port and one
// registered read port. The caller places the page bit in the address MSB.
// No reset on the array or read register so the block maps onto block RAM.
module weight_bank_sram #(
  parameter int AW = 12,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its last value when not enabled.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/weight_bank_mem.sv
// Double-buffered weight memory: NUM_BANKS parallel banks, each with an
// active (read-only) page and a shadow (write-only) page. Words are streamed
// into the shadow page round-robin across banks; swap exchanges the pages,
// deferred to the end of a load if one is in progress.
// Optional feature macro: WEIGHT_MEM_PARITY_EN adds a per-word even-parity
// bit and the rd_perr output.
//
// Handshake: a load word transfers on every rising edge where
// ld_valid && ld_ready; ld_ready is high exactly while the FSM is in LOAD and
// does not depend on ld_valid. The producer holds ld_data while ld_valid is
// high and ld_ready is low.
module weight_bank_mem
  import weight_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_BANKS  = DEF_NUM_BANKS
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            csen,
  input  logic                                            ld_start,
  input  logic [ld_len_width(ADDR_WIDTH, NUM_BANKS)-1:0]  ld_len,
  input  logic                                            ld_valid,
  output logic                                            ld_ready,
  input  logic [DATA_WIDTH-1:0]                           ld_data,
  output logic                                            ld_done,
  input  logic                                            swap,
  output logic                                            page_sel,
  input  logic                                            rdena,
  input  logic [ADDR_WIDTH-1:0]                           rd_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]                 rd_data,
  output logic                                            rd_valid
`ifdef WEIGHT_MEM_PARITY_EN
  , output logic [NUM_BANKS-1:0]                          rd_perr
`endif
);

  localparam int LEN_W  = ld_len_width(ADDR_WIDTH, NUM_BANKS);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int BSEL_W = (BANK_W == 0) ? 1 : BANK_W;
  localparam int MEM_AW = ADDR_WIDTH + 1;
`ifdef WEIGHT_MEM_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(NUM_BANKS) << ADDR_WIDTH;

  ld_state_e         state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  wr_cnt;
  logic              swap_pend;
  logic              page_q;
  logic              ld_done_q;
  logic              rd_valid_q;

  logic [LEN_W-1:0]      len_clamped;
  logic                  accept;
  logic                  last_word;
  logic [BSEL_W-1:0]     wr_bank;
  logic [ADDR_WIDTH-1:0] wr_word;
  logic [WORD_W-1:0]     wr_word_data;
  logic                  rd_en;

  assign len_clamped = (ld_len > MAX_LEN) ? MAX_LEN : ld_len;
  assign accept      = (state == ST_LOAD) && ld_valid;
  assign last_word   = accept && (wr_cnt == (len_q - LEN_W'(1)));
  assign wr_bank     = (BANK_W == 0) ? '0 : BSEL_W'(wr_cnt);
  assign wr_word     = ADDR_WIDTH'(wr_cnt >> BANK_W);
  assign rd_en       = csen && rdena;
`ifdef WEIGHT_MEM_PARITY_EN
  assign wr_word_data = {^ld_data, ld_data};
`else
  assign wr_word_data = ld_data;
`endif

  assign ld_ready = (state == ST_LOAD);
  assign ld_done  = ld_done_q;
  assign page_sel = page_q;
  assign rd_valid = rd_valid_q;

  // Load FSM, word counter, swap latch and active-page select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      wr_cnt    <= '0;
      swap_pend <= 1'b0;
      page_q    <= 1'b0;
      ld_done_q <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (swap) page_q <= ~page_q;
          if (ld_start) begin
            if (len_clamped == '0) begin
              ld_done_q <= 1'b1;
            end else begin
              state  <= ST_LOAD;
              len_q  <= len_clamped;
              wr_cnt <= '0;
            end
          end
        end
        ST_LOAD: begin
          // ld_start is ignored here; swap is deferred to the load exit.
          if (swap) swap_pend <= 1'b1;
          if (accept) begin
            wr_cnt <= wr_cnt + LEN_W'(1);
            if (last_word) begin
              state     <= ST_IDLE;
              wr_cnt    <= '0;
              ld_done_q <= 1'b1;
              swap_pend <= 1'b0;
              if (swap_pend || swap) page_q <= ~page_q;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read-valid tracks the registered read port latency of one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid_q <= 1'b0;
    else        rd_valid_q <= rd_en;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [WORD_W-1:0] q;

    weight_bank_sram #(
      .AW (MEM_AW),
      .W  (WORD_W)
    ) u_sram (
      .clk   (clk),
      .we    (accept && (wr_bank == BSEL_W'(b))),
      .waddr ({~page_q, wr_word}),
      .wdata (wr_word_data),
      .re    (rd_en),
      .raddr ({page_q, rd_addr}),
      .rdata (q)
    );

    // Output is forced to zero whenever no read result is pending.
    assign rd_data[b*DATA_WIDTH +: DATA_WIDTH] = rd_valid_q ? q[DATA_WIDTH-1:0] : '0;
`ifdef WEIGHT_MEM_PARITY_EN
    assign rd_perr[b] = rd_valid_q && (^q);
`endif
  end

endmodule

// File: tb/tb_weight_bank_mem.sv
// Self-checking bench for weight_bank_mem (default geometry 11/8/4).
// With WEIGHT_MEM_PARITY_EN defined it also covers the parity flag.
module tb_weight_bank_mem;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int NB    = 4;
  localparam int LW    = AW + $clog2(NB) + 1;
  localparam int RDW   = NB * DW;
  localparam int DEPTH = 1 << AW;
  localparam int MAXW  = NB * DEPTH;

  logic          clk;
  logic          rst_n;
  logic          csen;
  logic          ld_start;
  logic [LW-1:0] ld_len;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_done;
  logic          swap;
  logic          page_sel;
  logic          rdena;
  logic [AW-1:0] rd_addr;
  logic [RDW-1:0] rd_data;
  logic          rd_valid;
`ifdef WEIGHT_MEM_PARITY_EN
  logic [NB-1:0] rd_perr;
  logic [NB-1:0] exp_perr;
`endif

  int n_checks;
  int n_fail;
  logic [RDW-1:0] exp_q[$];
  logic [DW-1:0]  model [2][NB][DEPTH];
  logic           exp_page;

  weight_bank_mem #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_BANKS  (NB)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .csen     (csen),
    .ld_start (ld_start),
    .ld_len   (ld_len),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .ld_done  (ld_done),
    .swap     (swap),
    .page_sel (page_sel),
    .rdena    (rdena),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
`ifdef WEIGHT_MEM_PARITY_EN
    , .rd_perr (rd_perr)
`endif
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RDW-1:0] exp_word(input logic pg, input int addr);
    logic [RDW-1:0] w;
    for (int b = 0; b < NB; b++) w[b*DW +: DW] = model[pg][b][addr];
    return w;
  endfunction

  // Compare the registered read result against the head of the scoreboard.
  task automatic check_read(input string name);
    logic [RDW-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: read result with empty scoreboard", name);
    end else begin
      e = exp_q.pop_front();
      if (rd_valid !== 1'b1 || rd_data !== e) begin
        n_fail++;
        $display("FAIL %s: rd_valid=%b rd_data=%h, required rd_valid=1 rd_data=%h",
                 name, rd_valid, rd_data, e);
      end
    end
`ifdef WEIGHT_MEM_PARITY_EN
    n_checks++;
    if (rd_perr !== exp_perr) begin
      n_fail++;
      $display("FAIL %s_perr: rd_perr=%b, required %b", name, rd_perr, exp_perr);
    end
`endif
  endtask

  task automatic do_read(input int addr, input string name);
    csen = 1'b1; rdena = 1'b1; rd_addr = AW'(addr);
    exp_q.push_back(exp_word(exp_page, addr));
    step;
    csen = 1'b0; rdena = 1'b0;
    check_read(name);
  endtask

  task automatic do_swap_idle(input string name);
    swap = 1'b1;
    step;
    swap = 1'b0;
    exp_page = ~exp_page;
    n_checks++;
    if (page_sel !== exp_page) begin
      n_fail++;
      $display("FAIL %s: page_sel=%b, required %b", name, page_sel, exp_page);
    end
  endtask

  // Stream a load into the shadow page. Optional swap pulses at beats
  // swap_k1/swap_k2 (-1 = none), an ignored ld_start mid-load, and reads of
  // the active page on every cycle of the load.
  task automatic run_load(input logic [LW-1:0] len_drv, input bit seq_data,
                          input int swap_k1, input int swap_k2,
                          input bit restart_mid, input bit read_mid,
                          input string name);
    int  eff;
    int  k;
    int  cyc;
    bit  v;
    bit  rd_pend;
    bit  swapped;
    logic wp;
    eff = (int'(len_drv) > MAXW) ? MAXW : int'(len_drv);
    wp = ~exp_page;
    swapped = 1'b0;
    rd_pend = 1'b0;
    ld_start = 1'b1; ld_len = len_drv;
    step;
    ld_start = 1'b0;
    k = 0; cyc = 0;
    while (k < eff && cyc < eff * 4 + 50) begin
      v = ($urandom_range(0, 3) != 0);
      swap = (k == swap_k1 || k == swap_k2);
      if (swap) swapped = 1'b1;
      ld_start = restart_mid && (k == 2);
      if (ld_start) ld_len = LW'(1);
      if (read_mid) begin
        csen = 1'b1; rdena = 1'b1; rd_addr = AW'(k % 2);
        exp_q.push_back(exp_word(exp_page, k % 2));
      end
      n_checks++;
      if (ld_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_ready: beat %0d ld_ready=%b, required 1", name, k, ld_ready);
      end
      ld_valid = v;
      if (v) begin
        ld_data = seq_data ? DW'(k) : DW'($urandom_range(0, 255));
        model[wp][k % NB][k / NB] = ld_data;
      end
      step;
      cyc++;
      if (v) k++;
      if (read_mid) check_read({name, "_rd"});
      if (k < eff) begin
        n_checks++;
        if (ld_done !== 1'b0 || page_sel !== exp_page) begin
          n_fail++;
          $display("FAIL %s_mid: ld_done=%b page_sel=%b, required 0 and %b",
                   name, ld_done, page_sel, exp_page);
        end
      end
    end
    ld_valid = 1'b0; swap = 1'b0; ld_start = 1'b0; csen = 1'b0; rdena = 1'b0;
    n_checks++;
    if (k < eff) begin
      n_fail++;
      $display("FAIL %s_timeout: accepted %0d of %0d words", name, k, eff);
    end
    if (swapped) exp_page = ~exp_page;
    n_checks++;
    if (ld_done !== 1'b1 || page_sel !== exp_page || ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: ld_done=%b page_sel=%b ld_ready=%b, required 1 %b 0",
               name, ld_done, page_sel, ld_ready, exp_page);
    end
    step;
    n_checks++;
    if (ld_done !== 1'b0 || page_sel !== exp_page) begin
      n_fail++;
      $display("FAIL %s_after: ld_done=%b page_sel=%b, required 0 %b",
               name, ld_done, page_sel, exp_page);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; csen = 1'b0; ld_start = 1'b0; ld_len = '0; ld_valid = 1'b0;
    ld_data = '0; swap = 1'b0; rdena = 1'b0; rd_addr = '0;
    exp_page = 1'b0;
`ifdef WEIGHT_MEM_PARITY_EN
    exp_perr = '0;
`endif
    step; step;
    rst_n = 1'b1;
    step;
    n_checks++;
    if (page_sel !== 1'b0 || ld_ready !== 1'b0 || ld_done !== 1'b0 ||
        rd_valid !== 1'b0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset: page_sel=%b ld_ready=%b ld_done=%b rd_valid=%b rd_data=%h, required all 0",
               page_sel, ld_ready, ld_done, rd_valid, rd_data);
    end
  endtask

  task automatic test_basic;
    logic [RDW-1:0] e;
    run_load(LW'(8), 1'b1, -1, -1, 1'b0, 1'b0, "basic_load");
    do_swap_idle("basic_swap");
    e = {8'd7, 8'd6, 8'd5, 8'd4};
    n_checks++;
    if (exp_word(exp_page, 1) !== e) begin
      n_fail++;
      $display("FAIL basic_model: model word=%h, required %h", exp_word(exp_page, 1), e);
    end
    do_read(1, "basic_read1");
    do_read(0, "basic_read0");
  endtask

  task automatic test_swap_mid_load;
    run_load(LW'(8), 1'b0, 1, 3, 1'b1, 1'b0, "swap_mid");
    step;
    n_checks++;
    if (page_sel !== exp_page) begin
      n_fail++;
      $display("FAIL swap_once: page_sel=%b, required %b", page_sel, exp_page);
    end
    do_read(1, "swap_mid_read");
  endtask

  task automatic test_read_during_load;
    run_load(LW'(8), 1'b0, -1, -1, 1'b0, 1'b1, "rd_in_load");
  endtask

  task automatic test_csen_gate;
    csen = 1'b0; rdena = 1'b1; rd_addr = AW'(1);
    step;
    rdena = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL csen_gate: rd_valid=%b rd_data=%h, required 0 and 0", rd_valid, rd_data);
    end
  endtask

  task automatic test_read_on_toggle;
    csen = 1'b1; rdena = 1'b1; rd_addr = AW'(1); swap = 1'b1;
    exp_q.push_back(exp_word(exp_page, 1));
    step;
    csen = 1'b0; rdena = 1'b0; swap = 1'b0;
    exp_page = ~exp_page;
    check_read("toggle_old_page");
    n_checks++;
    if (page_sel !== exp_page) begin
      n_fail++;
      $display("FAIL toggle_page: page_sel=%b, required %b", page_sel, exp_page);
    end
    do_read(1, "toggle_new_page");
  endtask

  task automatic test_zero_len;
    ld_start = 1'b1; ld_len = '0; ld_valid = 1'b1; ld_data = 8'hEE;
    step;
    ld_start = 1'b0; ld_valid = 1'b0;
    n_checks++;
    if (ld_done !== 1'b1 || ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_done: ld_done=%b ld_ready=%b, required 1 0", ld_done, ld_ready);
    end
    step;
    n_checks++;
    if (ld_done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_pulse: ld_done=%b, required 0", ld_done);
    end
    do_swap_idle("zero_len_swap");
    do_read(0, "zero_len_nowrite");
  endtask

  task automatic test_clamp;
    run_load({LW{1'b1}}, 1'b0, -1, -1, 1'b0, 1'b0, "clamp");
    do_swap_idle("clamp_swap");
    do_read(DEPTH - 1, "clamp_top");
    do_read(0, "clamp_bottom");
  endtask

`ifdef WEIGHT_MEM_PARITY_EN
  task automatic test_parity;
    logic [AW:0] idx;
    idx = {exp_page, AW'(DEPTH - 1)};
    u_dut.g_bank[2].u_sram.mem[idx] = u_dut.g_bank[2].u_sram.mem[idx] ^ 9'd1;
    model[exp_page][2][DEPTH - 1] = model[exp_page][2][DEPTH - 1] ^ 8'd1;
    exp_perr = 4'b0100;
    do_read(DEPTH - 1, "parity_flip");
    exp_perr = '0;
    do_read(0, "parity_clean");
  endtask
`endif

  task automatic test_reset_abort;
    if (exp_page == 1'b0) do_swap_idle("abort_pre_swap");
    ld_start = 1'b1; ld_len = LW'(8);
    step;
    ld_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1; ld_data = DW'($urandom_range(0, 255));
      model[~exp_page][k % NB][k / NB] = ld_data;
      step;
    end
    ld_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_page = 1'b0;
    n_checks++;
    if (page_sel !== 1'b0 || ld_ready !== 1'b0 || ld_done !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_reset: page_sel=%b ld_ready=%b ld_done=%b rd_valid=%b, required all 0",
               page_sel, ld_ready, ld_done, rd_valid);
    end
    step;
    rst_n = 1'b1;
    ld_valid = 1'b1;
    step;
    ld_valid = 1'b0;
    n_checks++;
    if (ld_ready !== 1'b0 || ld_done !== 1'b0 || page_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: ld_ready=%b ld_done=%b page_sel=%b, required 0 0 0",
               ld_ready, ld_done, page_sel);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_basic;
    test_swap_mid_load;
    test_read_during_load;
    test_csen_gate;
    test_read_on_toggle;
    test_zero_len;
    test_clamp;
`ifdef WEIGHT_MEM_PARITY_EN
    test_parity;
`endif
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_bank_mem.md
WEIGHT_BANK_MEM -- requirements
Module: weight_bank_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, word address width per bank page.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, weight word width.
REQ-003 SHALL have parameter NUM_BANKS, default 4, number of parallel banks (power of two, 1..16).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port csen  input  1  chip enable; it gates the read port only.
REQ-007 SHALL have port ld_start  input  1  one-cycle pulse that begins a load into the shadow page.
REQ-008 SHALL have port ld_len  input  ADDR_WIDTH+$clog2(NUM_BANKS)+1  word count, sampled on ld_start.
REQ-009 SHALL have port ld_valid  input  1  load-data valid.
REQ-010 SHALL have port ld_ready  output  1  load-data ready.
REQ-011 SHALL have port ld_data  input  DATA_WIDTH  load word.
REQ-012 SHALL have port ld_done  output  1  one-cycle pulse after the last word is written.
REQ-013 SHALL have port swap  input  1  request to exchange the active and shadow pages.
REQ-014 SHALL have port page_sel  output  1  index of the active (readable) page.
REQ-015 SHALL have port rdena  input  1  read enable.
REQ-016 SHALL have port rd_addr  input  ADDR_WIDTH  read word address.
REQ-017 SHALL have port rd_data  output  NUM_BANKS*DATA_WIDTH  bank b occupies bits [b*DATA_WIDTH +: DATA_WIDTH].
REQ-018 SHALL have port rd_valid  output  1  rd_data is valid.

Function
REQ-019 SHALL hold two pages of 2**ADDR_WIDTH words per bank: the active page is read-only, the shadow page is write-only.
REQ-020 SHALL implement the FSM IDLE -> LOAD (on ld_start) -> IDLE (after the last word); a swap pending when LOAD exits is applied in that same exit cycle.
REQ-021 SHALL assert ld_ready only in LOAD.
REQ-022 SHALL write a word on each ld_valid&&ld_ready cycle; word k goes to bank k%NUM_BANKS, address k/NUM_BANKS, shadow page.
REQ-023 SHALL pulse ld_done the cycle after word ld_len-1 is accepted.
REQ-024 SHALL treat ld_len=0 as an immediate ld_done with no writes.
REQ-025 SHALL clamp ld_len values above NUM_BANKS*2**ADDR_WIDTH to that maximum.
REQ-026 SHALL ignore ld_start while in LOAD.
REQ-027 SHALL, on swap in IDLE, toggle page_sel on the next edge.
REQ-028 SHALL, on swap in LOAD, latch the request and toggle page_sel in the cycle ld_done is asserted; multiple swap requests during one load cause a single toggle.
REQ-029 SHALL, on csen&&rdena, present all banks at rd_addr of the active page on rd_data with rd_valid=1 one cycle later; otherwise rd_data=0 and rd_valid=0.
REQ-030 SHALL make a read issued in the same cycle as a page toggle return data from the old page.

Reset
REQ-031 SHALL reset the FSM to IDLE, page_sel=0, ld_ready=0, ld_done=0, rd_valid=0, rd_data=0, all counters and the swap latch to 0.
REQ-032 SHALL NOT clear the memory array on reset (contents undefined); an assertion during LOAD aborts the load.

Configuration
REQ-033 SHALL, when macro WEIGHT_MEM_PARITY_EN is defined, store an even-parity bit per word, check it on read, and add output rd_perr (NUM_BANKS wide, per-bank flag valid with rd_valid, reset 0); without the macro there is neither parity storage nor the rd_perr port.

Structure
REQ-034 SHALL place the FSM state enum, the default parameter values and the ld_len width function in package weight_mem_pkg.
REQ-035 SHALL instantiate NUM_BANKS copies of sub-module weight_bank_sram (1 write port and 1 registered read port, page bit as the MSB of the address, block-RAM inferable).

Verification
REQ-036 SHALL test: load ld_len=8 words 0..7 with NUM_BANKS=4, then swap, then read addr 1 -> rd_data={7,6,5,4}, rd_valid one cycle later.
REQ-037 SHALL test: swap pulsed in the middle of a load -> page_sel toggles in the ld_done cycle, exactly once.
REQ-038 SHALL test: a read during a shadow-page load -> old active data unchanged.
REQ-039 SHALL test: rdena=1 with csen=0 -> rd_data=0 and rd_valid=0.
REQ-040 SHALL test: ld_len=0 -> ld_done one cycle after ld_start with no writes; rst_n low mid-load -> IDLE, page_sel=0.
REQ-041 SHALL test, with WEIGHT_MEM_PARITY_EN defined: a forced bit flip in bank 2 -> rd_perr=4'b0100 with rd_valid.
